// File: rtl/id_stage_if.sv
// ID stage connection bundle: fetch input, regfile read port, EX/MEM/WB bypass taps and the ID/EX register.
// The master modport is the decode stage itself; the slave modport is its surrounding pipeline.
interface id_stage_if #(parameter int XLEN = 32);
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            id_ready;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rv1;
    logic [XLEN-1:0] rv2;
    logic [4:0]      ex_rd;
    logic            ex_we;
    logic            ex_is_load;
    logic [XLEN-1:0] ex_result;
    logic [4:0]      mem_rd;
    logic            mem_we;
    logic [XLEN-1:0] mem_result;
    logic [4:0]      wb_rd;
    logic            wb_we;
    logic [XLEN-1:0] wb_wdata;
    logic            flush;
    logic            ex_ready;
    logic            id_ex_valid;
    logic [XLEN-1:0] id_ex_pc;
    logic [31:0]     id_ex_instr;
    logic [XLEN-1:0] id_ex_a;
    logic [XLEN-1:0] id_ex_b;
    logic [XLEN-1:0] id_ex_imm;
    logic [4:0]      id_ex_rd;
    logic            id_ex_we;
    logic            id_ex_is_load;
    logic [31:0]     stall_count;

    modport master (
        input  if_valid, if_instr, if_pc, rv1, rv2,
               ex_rd, ex_we, ex_is_load, ex_result,
               mem_rd, mem_we, mem_result,
               wb_rd, wb_we, wb_wdata, flush, ex_ready,
        output id_ready, rs1, rs2,
               id_ex_valid, id_ex_pc, id_ex_instr, id_ex_a, id_ex_b, id_ex_imm,
               id_ex_rd, id_ex_we, id_ex_is_load, stall_count
    );

    modport slave (
        output if_valid, if_instr, if_pc, rv1, rv2,
               ex_rd, ex_we, ex_is_load, ex_result,
               mem_rd, mem_we, mem_result,
               wb_rd, wb_we, wb_wdata, flush, ex_ready,
        input  id_ready, rs1, rs2,
               id_ex_valid, id_ex_pc, id_ex_instr, id_ex_a, id_ex_b, id_ex_imm,
               id_ex_rd, id_ex_we, id_ex_is_load, stall_count
    );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: one-cycle latency into ID/EX; holds when EX stalls, inserts bubbles on RAW hazards.
// ID_FWD_EN selects EX/MEM/WB bypassing (load-use stall only); without it every pending writer stalls.
module id_stage #(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     reset,
    id_stage_if.master bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            we;
        logic            is_load;
    } bundle_t;

    logic [31:0]           instr;
    logic [6:0]            opcode;
    logic [4:0]            rd;
    logic                  uses_rs1, uses_rs2, dec_we;
    logic [31:0]           imm32;
    logic [1:0][4:0]       src_rs;
    logic [1:0][XLEN-1:0]  src_rv;
    logic [1:0]            src_used;
    logic [1:0][XLEN-1:0]  opnd;
    logic                  hazard, advance, load;
    logic                  valid_q, valid_d;
    bundle_t               bundle_q, bundle_d;
    logic [31:0]           stall_q, stall_d;

    assign instr    = bus.if_instr;
    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign bus.rs1  = instr[19:15];
    assign bus.rs2  = instr[24:20];
    assign uses_rs1 = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    assign uses_rs2 = opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH};
    assign dec_we   = !(opcode inside {OPC_STORE, OPC_BRANCH}) && (rd != 5'd0);
    assign src_rs   = {instr[24:20], instr[19:15]};
    assign src_rv   = {bus.rv2, bus.rv1};
    assign src_used = {uses_rs2, uses_rs1};

    always_comb begin
        imm32 = {{20{instr[31]}}, instr[31:20]};
        case (opcode)
            OPC_STORE:          imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:         imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC: imm32 = {instr[31:12], 12'b0};
            OPC_JAL:            imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            OPC_OP:             imm32 = '0;
            default:            ;
        endcase
    end

    // Later assignments override earlier ones, so the youngest writer wins and x0 beats everything.
    always_comb begin
        opnd = src_rv;
        for (int i = 0; i < 2; i++) begin
`ifdef ID_FWD_EN
            if (bus.wb_we && bus.wb_rd == src_rs[i])
                opnd[i] = bus.wb_wdata;
            if (bus.mem_we && bus.mem_rd == src_rs[i])
                opnd[i] = bus.mem_result;
            if (bus.ex_we && !bus.ex_is_load && bus.ex_rd == src_rs[i])
                opnd[i] = bus.ex_result;
`endif
            if (src_rs[i] == 5'd0)
                opnd[i] = '0;
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (src_used[i] && src_rs[i] != 5'd0) begin
`ifdef ID_FWD_EN
                if (valid_q && bus.ex_is_load && bus.ex_rd == src_rs[i])
                    hazard = 1'b1;
`else
                if ((valid_q && bus.ex_we && bus.ex_rd == src_rs[i]) ||
                    (bus.mem_we && bus.mem_rd == src_rs[i]) ||
                    (bus.wb_we && bus.wb_rd == src_rs[i]))
                    hazard = 1'b1;
`endif
            end
        end
    end

`ifndef ID_FWD_EN
    logic unused_fwd;
    assign unused_fwd = ^{bus.ex_result, bus.ex_is_load, bus.mem_result, bus.wb_wdata};
`endif

    assign advance      = !valid_q || bus.ex_ready;
    assign load         = bus.if_valid && advance && !hazard && !bus.flush;
    assign bus.id_ready = !reset && (bus.flush || (advance && !hazard));

    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (advance) begin
            valid_d = load;
            if (load)
                bundle_d = '{pc: bus.if_pc, instr: instr, a: opnd[0], b: opnd[1],
                             imm: XLEN'($signed(imm32)), rd: rd, we: dec_we,
                             is_load: (opcode == OPC_LOAD)};
        end
        stall_d = stall_q;
        if (!bus.flush && bus.if_valid && hazard && stall_q != 32'hFFFF_FFFF)
            stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
            stall_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
            stall_q  <= stall_d;
        end
    end

    assign bus.id_ex_valid   = valid_q;
    assign bus.id_ex_pc      = bundle_q.pc;
    assign bus.id_ex_instr   = bundle_q.instr;
    assign bus.id_ex_a       = bundle_q.a;
    assign bus.id_ex_b       = bundle_q.b;
    assign bus.id_ex_imm     = bundle_q.imm;
    assign bus.id_ex_rd      = bundle_q.rd;
    assign bus.id_ex_we      = bundle_q.we;
    assign bus.id_ex_is_load = bundle_q.is_load;
    assign bus.stall_count   = stall_q;
endmodule
